// File: rtl/mem_cache_pkg.sv
// Purpose : shared types and constants for the MEM-stage two-way read cache.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default geometry (SETS/TAG_W/ADDR_BASE), derived
// widths and the bit positions used to split a rebased byte address.
package mem_cache_pkg;

  localparam int SETS_DEF      = 64;
  localparam int TAG_W_DEF     = 10;
  localparam int ADDR_BASE_DEF = 1024;

  localparam int WORD_W = 32;
  localparam int LINE_W = 64;

  // Rebased address layout: [1:0] byte, [2] word in line, then index, then tag.
  localparam int WORD_BIT = 2;
  localparam int IDX_LSB  = 3;

  localparam int IDX_W_DEF   = $clog2(SETS_DEF);
  localparam int TAG_LSB_DEF = IDX_LSB + IDX_W_DEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  // Tag field position for a given number of sets.
  function automatic int tag_lsb(input int sets);
    return IDX_LSB + $clog2(sets);
  endfunction

endpackage

// File: rtl/mem_cache_array.sv
// Purpose : per-set storage for a 2-way cache: {valid, tag, 64-bit line} x2 plus one LRU bit.
// Latency : lookup is combinational; fill / invalidate / LRU update take effect at the next clk edge.
// Backpressure: none; the controller decides when each write port fires.
//
// Ports: clk, rst (sync, active-high, clears valid and LRU bits);
//   index/tag/word_sel select the lookup; hit, hit_way, word, victim_way are the results;
//   fill_en/fill_way/fill_data write a line at index; inval_en clears any way hitting tag;
//   lru_en/lru_val write the LRU bit at index.
module mem_cache_array
  import mem_cache_pkg::*;
#(
  parameter int SETS  = SETS_DEF,
  parameter int TAG_W = TAG_W_DEF,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index,
  input  logic [TAG_W-1:0]  tag,
  input  logic              word_sel,
  output logic              hit,
  output logic              hit_way,
  output logic [WORD_W-1:0] word,
  output logic              victim_way,
  input  logic              fill_en,
  input  logic              fill_way,
  input  logic [LINE_W-1:0] fill_data,
  input  logic              inval_en,
  input  logic              lru_en,
  input  logic              lru_val
);

  logic [SETS-1:0]   valid [2];
  logic [SETS-1:0]   lru;
  logic [TAG_W-1:0]  tags  [2][SETS];
  logic [LINE_W-1:0] lines [2][SETS];

  logic              hit0;
  logic              hit1;
  logic [LINE_W-1:0] hit_line;

  assign hit0     = valid[0][index] && (tags[0][index] == tag);
  assign hit1     = valid[1][index] && (tags[1][index] == tag);
  assign hit      = hit0 || hit1;
  // Only meaningful when hit is set; a tag never lives in both ways because
  // lines are filled only on a miss.
  assign hit_way  = ~hit0;
  assign hit_line = hit0 ? lines[0][index] : lines[1][index];
  assign word     = word_sel ? hit_line[63:32] : hit_line[31:0];

  // An empty way is always used before evicting; way0 wins when both are empty.
  assign victim_way = !valid[0][index] ? 1'b0 :
                      !valid[1][index] ? 1'b1 : lru[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
    end else begin
      if (fill_en) valid[fill_way][index] <= 1'b1;
      if (inval_en) begin
        if (hit0) valid[0][index] <= 1'b0;
        if (hit1) valid[1][index] <= 1'b0;
      end
      if (lru_en) lru[index] <= lru_val;
    end
  end

  // Tag and data need no reset: they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_way][index]  <= tag;
      lines[fill_way][index] <= fill_data;
    end
  end

endmodule

// File: rtl/mem_cache_controller.sv
// Purpose : two-way set-associative read cache between the MEM stage and the SRAM controller;
//           write-through, no write-allocate, a write hit invalidates the matching way.
// Latency : read hit completes in the request cycle; miss/write complete on the sram_ready cycle.
// Backpressure: ready=0 freezes the pipeline; requester holds its request until ready=1.
//
// Ports: clk, rst (sync, active-high); wr_en/rd_en/address/wdata from MEM; rdata/ready back;
//   sram_wr_en/sram_rd_en/sram_address/sram_wdata/sram_rdata/sram_ready to the SRAM controller.
// Optional: define MEM_CACHE_STATS_EN for saturating hit_count/miss_count outputs.
module mem_cache_controller
  import mem_cache_pkg::*;
#(
  parameter int SETS      = SETS_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_wr_en,
  output logic        sram_rd_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
`ifdef MEM_CACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic        sram_ready
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = tag_lsb(SETS);

  state_t state;

  logic [31:0]      a;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             word_sel;
  logic             unused_addr_bits;

  logic        hit;
  logic        hit_way;
  logic [31:0] hit_word;
  logic        victim_way;
  logic        fill_en;
  logic        inval_en;
  logic        lru_en;
  logic        lru_val;
  logic        rd_hit;
  logic        miss_done;

  assign a        = address - 32'(ADDR_BASE);
  assign index    = a[IDX_LSB +: IDX_W];
  assign tag      = a[TAG_LSB +: TAG_W];
  assign word_sel = a[WORD_BIT];
  assign unused_addr_bits = ^{a[31:TAG_LSB+TAG_W], a[1:0]};

  // wr_en has priority over a (illegal) simultaneous rd_en.
  assign rd_hit    = (state == IDLE) && rd_en && !wr_en && hit;
  assign miss_done = (state == READ_MISS) && sram_ready;

  mem_cache_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .tag        (tag),
    .word_sel   (word_sel),
    .hit        (hit),
    .hit_way    (hit_way),
    .word       (hit_word),
    .victim_way (victim_way),
    .fill_en    (fill_en),
    .fill_way   (victim_way),
    .fill_data  (sram_rdata),
    .inval_en   (inval_en),
    .lru_en     (lru_en),
    .lru_val    (lru_val)
  );

  // Hits must answer in the request cycle, so the handshake outputs are
  // decoded from the registered state plus the live request.
  always_comb begin
    ready        = 1'b1;
    rdata        = '0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    fill_en      = 1'b0;
    inval_en     = 1'b0;
    lru_en       = 1'b0;
    lru_val      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          ready    = 1'b0;
          inval_en = 1'b1;
        end else if (rd_en) begin
          if (hit) begin
            rdata   = hit_word;
            lru_en  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            ready = 1'b0;
          end
        end
      end
      READ_MISS: begin
        sram_rd_en   = 1'b1;
        sram_address = address;
        ready        = sram_ready;
        if (sram_ready) begin
          rdata   = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
          fill_en = 1'b1;
          lru_en  = 1'b1;
          lru_val = ~victim_way;
        end
      end
      WRITE: begin
        sram_wr_en   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        ready        = sram_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en)             state <= WRITE;
          else if (rd_en && !hit) state <= READ_MISS;
        end
        READ_MISS: if (sram_ready) state <= IDLE;
        WRITE:     if (sram_ready) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef MEM_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && hit_count != 32'hFFFF_FFFF)     hit_count  <= hit_count + 32'd1;
      if (miss_done && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = rd_hit ^ miss_done;
`endif

endmodule

// File: doc/mem_cache_controller.md
Name: mem_cache_controller

Overview:
- Two-way set-associative read cache placed between the MEM stage and the SRAM controller.
- Read hits return in the same cycle, with no SRAM access.
- Read misses fetch a 64-bit line (two words) from the SRAM controller and fill it into the cache.
- Writes are write-through with no write-allocate; a write that hits invalidates the matching way.
- ready feeds the pipeline freeze exactly as the SRAM controller's ready does today.

Parameters:
- SETS, 64, number of sets; index width = log2(SETS).
- TAG_W, 10, tag bits stored per way.
- ADDR_BASE, 1024, data-memory base subtracted from the byte address before decoding.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  MEM-stage store request
- rd_en  in  1  MEM-stage load request
- address  in  32  byte address (ALU result)
- wdata  in  32  store data (Val_Rm)
- rdata  out  32  load data
- ready  out  1  request complete or idle; 0 freezes the pipeline
- sram_wr_en  out  1  write request to SRAM controller
- sram_rd_en  out  1  line-read request to SRAM controller
- sram_address  out  32  byte address forwarded to SRAM controller
- sram_wdata  out  32  store data forwarded
- sram_rdata  in  64  line data; word0 in [31:0]
- sram_ready  in  1  SRAM controller done

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset clears all valid bits, all LRU bits and the state (to IDLE).
- Outputs after reset: ready=1, sram_wr_en=0, sram_rd_en=0, rdata=0.
- Address decode: a = address - ADDR_BASE. Word select = a[2], index = a[2+log2(SETS):3], tag = next TAG_W bits above the index.
- Requester contract: holds wr_en/rd_en/address/wdata stable until ready=1.
- Both wr_en and rd_en asserted is illegal; wr_en wins.
- FSM states: IDLE, READ_MISS, WRITE.
- IDLE, no request: ready=1.
- IDLE, rd_en with a hit in way w:
  - ready=1 and rdata = selected word, combinationally in the same cycle.
  - At the clock edge, LRU[index] = ~w.
- IDLE, rd_en with a miss: ready=0; go to READ_MISS.
- IDLE, wr_en: ready=0; on the same edge, clear valid in any hitting way; go to WRITE.
- READ_MISS:
  - sram_rd_en=1, sram_address=address, held until sram_ready.
  - On the sram_ready cycle: ready=1 and rdata = word of sram_rdata chosen by a[2].
  - At that edge: fill the victim way (tag, data, valid=1), set LRU to the other way, return to IDLE.
  - Victim selection: first invalid way (way0 preferred), otherwise the LRU way.
- WRITE:
  - sram_wr_en=1, sram_address=address, sram_wdata=wdata, held until sram_ready.
  - On the sram_ready cycle: ready=1; return to IDLE.
- Request timing:
  - A request is sampled again in IDLE on the cycle after completion.
  - The pipeline advances on a ready=1 edge, so back-to-back requests cost no bubble on hits.
- rdata when not completing a read: 0.
- sram_rdata and sram_ready are ignored outside the wait states.
- Reset mid-operation (rst in READ_MISS or WRITE):
  - Return to IDLE and drop SRAM requests from the next cycle.
  - No line fill occurs; the SRAM controller is reset by the same rst.
- Never more than one outstanding SRAM request.

Optional Feature:
- Macro: MEM_CACHE_STATS_EN.
- With the macro defined:
  - Extra outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on each completed read hit; miss_count on each completed read miss (at the fill edge).
  - Writes are not counted. Both counters saturate at 0xFFFFFFFF.
- Without the macro: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package mem_cache_pkg:
  - FSM state enum (IDLE/READ_MISS/WRITE).
  - SETS/TAG_W/ADDR_BASE defaults and derived index and offset widths.
  - Field-extract constants.
- Sub-module mem_cache_array:
  - Holds per-set storage: 2 ways × {valid, tag, 64-bit data}, plus the LRU bit.
  - Combinational lookup returning hit, hit_way and word.
  - Synchronous ports for fill, invalidate and LRU update.
  - Synchronous clear on rst.
- The controller owns the FSM and the SRAM handshake.

Test Plan:
- Cold read:
  - Stimulus: rd_en at address 1024; SRAM returns 0x22222222_11111111 after 5 cycles.
  - Required: ready=0 for 5 cycles, then ready=1 with rdata=0x11111111.
  - Follow-up: the next read of 1028 hits in the same cycle with rdata=0x22222222 and no sram_rd_en.
- Eviction/LRU:
  - Stimulus: fill set 0 from addresses 1024 and 1024+512 (same index, different tag), then read 1024 (hit), then read 1024+1024.
  - Required: the third tag evicts the 1024+512 line. Reading 1024 still hits; reading 1024+512 misses.
- Write invalidate:
  - Stimulus: cache 1032, then wr_en to 1032 with wdata=0xDEADBEEF.
  - Required: sram_wr_en held until sram_ready, and sram_wdata=0xDEADBEEF.
  - Follow-up: the next read of 1032 misses and issues sram_rd_en.
- Write miss:
  - Stimulus: wr_en to an uncached address.
  - Required: no fill occurs; a subsequent read of that address misses.
- Reset mid-miss:
  - Stimulus: assert rst 2 cycles into READ_MISS.
  - Required: next cycle ready=1 and sram_rd_en=0; all lookups miss afterwards.
- Stats (MEM_CACHE_STATS_EN defined):
  - Stimulus: 3 hits and 2 misses.
  - Required: hit_count=3, miss_count=2; both are 0 after rst.
